acceptance_filter: RTL and testbench



---
 rtl/acceptance_filter_if.sv | 25 ++
 rtl/acceptance_filter.sv | 146 ++++++++++++++
 tb/tb_acceptance_filter.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/acceptance_filter_if.sv
// Decoder-to-filter-to-RX-FIFO signal bundle for the CAN acceptance filter.
// Latency: n/a (wires only).
// Backpressure: i_rx_full from the FIFO side; frames arriving while busy are lost.
// Ports: i_can_ready/i_rx_message from the frame decoder, i_rx_full from the FIFO,
//        o_rx_w_en/o_rx_fifo_w_data to the FIFO, o_acfbsy status.
interface acceptance_filter_if;
  logic         i_can_ready;
  logic [127:0] i_rx_message;
  logic         i_rx_full;
  logic         o_rx_w_en;
  logic [127:0] o_rx_fifo_w_data;
  logic         o_acfbsy;

  // master: decoder/FIFO side that feeds the filter
  modport master (
    output i_can_ready, i_rx_message, i_rx_full,
    input  o_rx_w_en, o_rx_fifo_w_data, o_acfbsy
  );

  // slave: the acceptance filter itself
  modport slave (
    input  i_can_ready, i_rx_message, i_rx_full,
    output o_rx_w_en, o_rx_fifo_w_data, o_acfbsy
  );
endinterface

// File: rtl/acceptance_filter.sv
// CAN RX acceptance filter: 4 mask/ID pairs, accepted frames written to the RX FIFO.
// Latency: strobe edge sampled at edge N -> o_rx_w_en pulse in the cycle after N+2.
// Backpressure: stalls in WAIT_FIFO while i_rx_full (drops instead with AF_DROP_ON_FULL_EN).
// Ports: i_sys_clk, i_reset (async, active-high); rx_if (slave modport) carries the
//        decoder strobe/message, FIFO full, FIFO write enable/data and busy flag;
//        i_afmr1..4 masks (1 = compare), i_afir1..4 IDs, i_uaf1..4 filter enables.
// Build option: define AF_DROP_ON_FULL_EN to discard accepted frames when the FIFO is full.
module acceptance_filter (
  input  logic                      i_sys_clk,
  input  logic                      i_reset,
  acceptance_filter_if.slave        rx_if,
  input  logic [31:0]               i_afmr1,
  input  logic [31:0]               i_afmr2,
  input  logic [31:0]               i_afmr3,
  input  logic [31:0]               i_afmr4,
  input  logic [31:0]               i_afir1,
  input  logic [31:0]               i_afir2,
  input  logic [31:0]               i_afir3,
  input  logic [31:0]               i_afir4,
  input  logic                      i_uaf1,
  input  logic                      i_uaf2,
  input  logic                      i_uaf3,
  input  logic                      i_uaf4
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FILTER    = 3'd1,
    S_WRITE     = 3'd2,
    S_DISCARD   = 3'd3
`ifndef AF_DROP_ON_FULL_EN
    ,S_WAIT_FIFO = 3'd4
`endif
  } state_t;

  state_t       state_q, state_d;
  logic         phase_q, phase_d;    // FILTER runs two cycles: compare, then decide
  logic         hit_q,   hit_d;      // registered accept decision
  logic         hist_q;              // previous i_can_ready sample for edge detect
  logic [127:0] msg_q,   msg_d;
  logic         w_en_q,  w_en_d;
  logic [127:0] wdata_q, wdata_d;
  logic         busy_q,  busy_d;

  logic         can_edge;
  logic [31:0]  id_word;
  logic [3:0]   match;
  logic [3:0]   uaf;
  logic         accept;

  assign can_edge = rx_if.i_can_ready & ~hist_q;
  assign id_word  = msg_q[127:96];

  // A filter matches when every masked bit of the ID equals the programmed ID bit.
  assign match[0] = ((id_word ^ i_afir1) & i_afmr1) == 32'd0;
  assign match[1] = ((id_word ^ i_afir2) & i_afmr2) == 32'd0;
  assign match[2] = ((id_word ^ i_afir3) & i_afmr3) == 32'd0;
  assign match[3] = ((id_word ^ i_afir4) & i_afmr4) == 32'd0;
  assign uaf      = {i_uaf4, i_uaf3, i_uaf2, i_uaf1};

  // No enabled filter means pass-all.
  assign accept   = (uaf == 4'd0) | (|(uaf & match));

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    hit_d   = hit_q;
    msg_d   = msg_q;
    case (state_q)
      S_IDLE: begin
        phase_d = 1'b0;
        if (can_edge) begin
          msg_d   = rx_if.i_rx_message;
          state_d = S_FILTER;
        end
      end
      S_FILTER: begin
        if (!phase_q) begin
          hit_d   = accept;
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (!hit_q) begin
            state_d = S_DISCARD;
          end else if (rx_if.i_rx_full) begin
`ifdef AF_DROP_ON_FULL_EN
            state_d = S_DISCARD;
`else
            state_d = S_WAIT_FIFO;
`endif
          end else begin
            state_d = S_WRITE;
          end
        end
      end
`ifndef AF_DROP_ON_FULL_EN
      S_WAIT_FIFO: begin
        if (!rx_if.i_rx_full) begin
          state_d = S_WRITE;
        end
      end
`endif
      S_WRITE:   state_d = S_IDLE;
      S_DISCARD: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_comb begin
    w_en_d  = (state_d == S_WRITE);
    busy_d  = (state_d != S_IDLE);
    wdata_d = wdata_q;
    if ((state_d == S_WRITE) && (state_q != S_WRITE)) begin
      wdata_d = msg_q;
    end
  end

  always_ff @(posedge i_sys_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      phase_q <= 1'b0;
      hit_q   <= 1'b0;
      hist_q  <= 1'b0;
      msg_q   <= 128'd0;
      w_en_q  <= 1'b0;
      wdata_q <= 128'd0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      hit_q   <= hit_d;
      // History tracks the strobe in every state so a held level never retriggers.
      hist_q  <= rx_if.i_can_ready;
      msg_q   <= msg_d;
      w_en_q  <= w_en_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
    end
  end

  assign rx_if.o_rx_w_en        = w_en_q;
  assign rx_if.o_rx_fifo_w_data = wdata_q;
  assign rx_if.o_acfbsy         = busy_q;

endmodule

// File: tb/tb_acceptance_filter.sv
// Directed self-checking bench for acceptance_filter.
// Latency: checks each cycle of a frame at the falling edge.
// Backpressure: exercises FIFO-full stall (or drop when AF_DROP_ON_FULL_EN is defined).
module tb_acceptance_filter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] afmr [4];
  logic [31:0] afir [4];
  logic [3:0]  uaf;

  int errors = 0;
  int checks = 0;
  int wr_cnt = 0;
  int wr_mark;

  acceptance_filter_if bus ();

  acceptance_filter dut (
    .i_sys_clk (clk),
    .i_reset   (rst),
    .rx_if     (bus.slave),
    .i_afmr1   (afmr[0]),
    .i_afmr2   (afmr[1]),
    .i_afmr3   (afmr[2]),
    .i_afmr4   (afmr[3]),
    .i_afir1   (afir[0]),
    .i_afir2   (afir[1]),
    .i_afir3   (afir[2]),
    .i_afir4   (afir[3]),
    .i_uaf1    (uaf[0]),
    .i_uaf2    (uaf[1]),
    .i_uaf3    (uaf[2]),
    .i_uaf4    (uaf[3])
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.o_rx_w_en === 1'b1) wr_cnt = wr_cnt + 1;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; strobe is sampled at the next rising edge (edge N).
  task automatic frame(input string tag, input logic [127:0] msg, input bit exp_acc,
                       input logic [127:0] prev);
    int base;
    base = wr_cnt;
    bus.i_rx_message = msg;
    bus.i_can_ready  = 1'b1;
    @(negedge clk);                                  // after N: FILTER
    bus.i_can_ready = 1'b0;
    check({tag, "_bsy_n0"}, 128'(bus.o_acfbsy), 128'd1);
    check({tag, "_wen_n0"}, 128'(bus.o_rx_w_en), 128'd0);
    @(negedge clk);                                  // after N+1
    check({tag, "_bsy_n1"}, 128'(bus.o_acfbsy), 128'd1);
    @(negedge clk);                                  // after N+2: WRITE or DISCARD
    check({tag, "_wen_n2"}, 128'(bus.o_rx_w_en), exp_acc ? 128'd1 : 128'd0);
    check({tag, "_dat_n2"}, bus.o_rx_fifo_w_data, exp_acc ? msg : prev);
    check({tag, "_bsy_n2"}, 128'(bus.o_acfbsy), 128'd1);
    @(negedge clk);                                  // after N+3: IDLE
    check({tag, "_bsy_n3"}, 128'(bus.o_acfbsy), 128'd0);
    check({tag, "_wen_n3"}, 128'(bus.o_rx_w_en), 128'd0);
    check({tag, "_dat_n3"}, bus.o_rx_fifo_w_data, exp_acc ? msg : prev);
    check({tag, "_wrcnt"}, 128'(wr_cnt - base), exp_acc ? 128'd1 : 128'd0);
  endtask

  logic [127:0] msg_a, msg_p, msg_r, msg_f, msg_h;
  logic [31:0]  masks [4];

  initial begin
    masks[0] = 32'h7FFF_FFFE;
    masks[1] = 32'h3FFF_FFFC;
    masks[2] = 32'h1FFF_FFF8;
    masks[3] = 32'h0FFF_FFF0;
    for (int i = 0; i < 4; i++) begin
      afmr[i] = 32'd0;
      afir[i] = 32'hFFFF_FFFF;
    end
    uaf = 4'd0;
    bus.i_can_ready  = 1'b0;
    bus.i_rx_message = 128'd0;
    bus.i_rx_full    = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_wen", 128'(bus.o_rx_w_en), 128'd0);
    check("rst_dat", bus.o_rx_fifo_w_data, 128'd0);
    check("rst_bsy", 128'(bus.o_acfbsy), 128'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single filter accept
    afmr[0] = masks[0];
    uaf     = 4'b0001;
    msg_a   = {32'hFFFF_FFFF, {24{4'hA}}};
    frame("f1", msg_a, 1'b1, 128'd0);

    // Each of filters 2..4 alone, distinct data per frame
    for (int i = 1; i < 4; i++) begin
      afmr[i] = masks[i];
      uaf     = 4'(1 << i);
      msg_p   = {32'hFFFF_FFFF, {24{4'hA}} ^ 96'(i)};
      frame($sformatf("f%0d", i + 1), msg_p, 1'b1, 128'd0);
    end

    // Pass-all
    uaf   = 4'b0000;
    msg_p = {32'h1234_5678, 96'h0123_4567_89AB_CDEF_0011_2233};
    frame("pass", msg_p, 1'b1, 128'd0);

    // Reject: all four enabled, ID differs in compared bits 24, 19, 7
    uaf   = 4'b1111;
    msg_r = {32'hFEF7_FF7F, 96'h5555_5555_5555_5555_5555_5555};
    frame("rej", msg_r, 1'b0, msg_p);

    // Same ID accepted once filter 4 is programmed with it
    afir[3] = 32'hFEF7_FF7F;
    frame("f4id", msg_r, 1'b1, 128'd0);
    afir[3] = 32'hFFFF_FFFF;

    // FIFO full for 5 sampled edges
    uaf   = 4'b0000;
    msg_f = {32'hCAFE_0001, 96'hDEAD_BEEF_0000_1111_2222_3333};
    wr_mark = wr_cnt;
    bus.i_rx_message = msg_f;
    bus.i_rx_full    = 1'b1;
    bus.i_can_ready  = 1'b1;
    @(negedge clk);
    bus.i_can_ready = 1'b0;
    check("full_bsy_n0", 128'(bus.o_acfbsy), 128'd1);
    @(negedge clk);
    check("full_bsy_n1", 128'(bus.o_acfbsy), 128'd1);
`ifdef AF_DROP_ON_FULL_EN
    @(negedge clk);
    check("full_bsy_n2", 128'(bus.o_acfbsy), 128'd1);
    check("full_wen_n2", 128'(bus.o_rx_w_en), 128'd0);
    @(negedge clk);
    check("full_bsy_n3", 128'(bus.o_acfbsy), 128'd0);
    bus.i_rx_full = 1'b0;
    repeat (3) @(negedge clk);
    check("full_drop_wrcnt", 128'(wr_cnt - wr_mark), 128'd0);
`else
    for (int k = 2; k <= 4; k++) begin
      @(negedge clk);
      check($sformatf("full_bsy_n%0d", k), 128'(bus.o_acfbsy), 128'd1);
      check($sformatf("full_wen_n%0d", k), 128'(bus.o_rx_w_en), 128'd0);
    end
    bus.i_rx_full = 1'b0;
    @(negedge clk);
    check("full_wen", 128'(bus.o_rx_w_en), 128'd1);
    check("full_dat", bus.o_rx_fifo_w_data, msg_f);
    check("full_bsy", 128'(bus.o_acfbsy), 128'd1);
    @(negedge clk);
    check("full_bsy_end", 128'(bus.o_acfbsy), 128'd0);
    check("full_wrcnt", 128'(wr_cnt - wr_mark), 128'd1);
`endif

    // Held strobe: one write only, no retrigger after returning to IDLE
    msg_h = {32'h0BAD_F00D, 96'h1111_2222_3333_4444_5555_6666};
    wr_mark = wr_cnt;
    bus.i_rx_message = msg_h;
    bus.i_can_ready  = 1'b1;
    repeat (6) @(negedge clk);
    check("held_bsy", 128'(bus.o_acfbsy), 128'd0);
    bus.i_can_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("held_wrcnt", 128'(wr_cnt - wr_mark), 128'd1);
    check("held_dat", bus.o_rx_fifo_w_data, msg_h);

    // Reset asserted while in FILTER
    wr_mark = wr_cnt;
    bus.i_rx_message = msg_a;
    bus.i_can_ready  = 1'b1;
    @(negedge clk);
    bus.i_can_ready = 1'b0;
    rst = 1'b1;
    #1;
    check("rstf_wen", 128'(bus.o_rx_w_en), 128'd0);
    check("rstf_dat", bus.o_rx_fifo_w_data, 128'd0);
    check("rstf_bsy", 128'(bus.o_acfbsy), 128'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("rstf_wrcnt", 128'(wr_cnt - wr_mark), 128'd0);

    // Strobe already high at reset release counts as an edge
    rst = 1'b1;
    bus.i_rx_message = msg_p;
    bus.i_can_ready  = 1'b1;
    @(negedge clk);
    wr_mark = wr_cnt;
    rst = 1'b0;
    @(negedge clk);
    check("rel_bsy", 128'(bus.o_acfbsy), 128'd1);
    repeat (3) @(negedge clk);
    bus.i_can_ready = 1'b0;
    check("rel_wrcnt", 128'(wr_cnt - wr_mark), 128'd1);
    check("rel_dat", bus.o_rx_fifo_w_data, msg_p);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
